arb_rr8: RTL and testbench

Eight-way round-robin arbiter that shares a single resource among eight requesters and drives the team's `decoder3to8` to produce the one-hot grant vector. It sits between requester agents and the shared datapath. Responsibilities:
- Pick a winner fairly.
- Hold the grant until the owner finishes or times out.
- Insert one turnaround cycle between owners.

---
 rtl/arb_pkg.sv | 12 +
 rtl/decoder3to8.sv | 13 +
 rtl/arb_rr8.sv | 108 ++++++++++
 tb/tb_arb_rr8.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter.
package arb_pkg;

  localparam int unsigned ARB_N = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StGap  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/decoder3to8.sv
// Enabled 3-to-8 one-hot decoder.
module decoder3to8 (
  input  logic [2:0] w,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (en) y[w] = 1'b1;
  end

endmodule

// File: rtl/arb_rr8.sv
// Eight-way round-robin arbiter with hold timeout and one-cycle turnaround between owners.
module arb_rr8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  arb_state_t       state_q, state_d;
  logic [2:0]       gnt_id_q, gnt_id_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic             pick_found;
  logic [2:0]       pick_idx;
  logic             rel_done, rel_drop, rel_limit;

  // Rotate req so ptr lands on bit 0, take the lowest set bit, then undo the rotation.
  function automatic logic [3:0] rr_pick(input logic [7:0] req_v, input logic [2:0] ptr_v);
    logic [7:0] rot;
    logic [2:0] off;
    logic       found;
    for (int i = 0; i < ARB_N; i++) begin
      rot[i] = req_v[ptr_v + 3'(i)];
    end
    found = 1'b0;
    off   = 3'd0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = 3'(i);
      end
    end
    return {found, 3'(ptr_v + off)};
  endfunction

  assign {pick_found, pick_idx} = rr_pick(req, ptr_q);

  assign rel_done  = done;
  assign rel_drop  = ~req[gnt_id_q];
  assign rel_limit = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      StBusy: begin
        if (rel_done || rel_drop || rel_limit) begin
          state_d   = StGap;
          timeout_d = rel_limit && !rel_done && !rel_drop;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Idle and gap arbitrate identically; gap just never holds.
        if (pick_found) begin
          state_d  = StBusy;
          gnt_id_d = pick_idx;
          ptr_d    = pick_idx + 3'd1;
          cnt_d    = CNT_W'(1);
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_id_q  <= 3'd0;
      ptr_q     <= 3'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  decoder3to8 u_dec (
    .w  (gnt_id_q),
    .en (state_q == StBusy),
    .y  (gnt)
  );

  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q == StBusy);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arb_rr8.sv
// Directed-vector bench for arb_rr8: table of per-edge vectors plus hand-written multi-cycle sequences.
module tb_arb_rr8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  arb_rr8 #(
    .MAX_HOLD (8),
    .CNT_W    (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [7:0] q, input logic d, input logic [7:0] g,
                     input logic [2:0] id, input logic b, input logic t);
    vec_t v;
    v.rst_n = r; v.req = q; v.done = d; v.gnt = g; v.id = id; v.busy = b; v.to = t;
    vecs.push_back(v);
  endtask

  // Drive inputs, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic r, input logic [7:0] q, input logic d);
    rst_n = r;
    req   = q;
    done  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [7:0] g, input logic [2:0] id,
                            input logic b, input logic t);
    n_vec++;
    if ({gnt, gnt_id, busy, timeout} !== {g, id, b, t}) begin
      n_err++;
      $display("FAIL %s: got gnt=%h id=%0d busy=%b to=%b, expected gnt=%h id=%0d busy=%b to=%b",
               name, gnt, gnt_id, busy, timeout, g, id, b, t);
    end
  endtask

  initial begin
    logic [7:0] one;
    one   = 8'h01;
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;

    // Reset and idle
    add(0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(0, 8'hFF, 0, 8'h00, 0, 0, 0);
    add(1, 8'h00, 0, 8'h00, 0, 0, 0);
    // Rotation: every requester once, gap between, then wrap to 0
    for (int i = 0; i < 8; i++) begin
      add(1, 8'hFF, 0, one << i, 3'(i), 1, 0);
      add(1, 8'hFF, 1, 8'h00, 3'(i), 0, 0);
    end
    add(1, 8'hFF, 0, 8'h01, 0, 1, 0);
    // Pointer skip: grant 2 (ptr=3), then req=05 wraps to 0, then ptr=1 picks 2
    add(1, 8'h04, 1, 8'h00, 0, 0, 0);
    add(1, 8'h04, 0, 8'h04, 2, 1, 0);
    add(1, 8'h05, 1, 8'h00, 2, 0, 0);
    add(1, 8'h05, 0, 8'h01, 0, 1, 0);
    add(1, 8'h05, 1, 8'h00, 0, 0, 0);
    add(1, 8'h05, 0, 8'h04, 2, 1, 0);
    // Owner drops req: gap without timeout, then idle keeps gnt_id (ptr ends at 3)
    add(1, 8'h00, 0, 8'h00, 2, 0, 0);
    add(1, 8'h00, 0, 8'h00, 2, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].done);
      expect_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].busy, vecs[i].to);
    end

    // Timeout: lone requester 4 holds for 8 cycles, gap with timeout, regrant
    for (int c = 1; c <= 8; c++) begin
      step(1, 8'h10, 0);
      expect_out($sformatf("hold4_c%0d", c), 8'h10, 4, 1, 0);
    end
    step(1, 8'h10, 0);
    expect_out("timeout_gap", 8'h00, 4, 0, 1);
    step(1, 8'h10, 0);
    expect_out("timeout_regrant", 8'h10, 4, 1, 0);

    // Hand over to 5, then done on the 8th hold cycle: no timeout
    step(1, 8'h20, 0);
    expect_out("drop4_gap", 8'h00, 4, 0, 0);
    step(1, 8'h20, 0);
    expect_out("grant5", 8'h20, 5, 1, 0);
    for (int c = 2; c <= 8; c++) begin
      step(1, 8'h20, 0);
      expect_out($sformatf("hold5_c%0d", c), 8'h20, 5, 1, 0);
    end
    step(1, 8'h20, 1);
    expect_out("done_at_limit", 8'h00, 5, 0, 0);

    // Regrant 5, then drop req mid-grant: gap without timeout
    step(1, 8'h20, 0);
    expect_out("regrant5", 8'h20, 5, 1, 0);
    step(1, 8'h20, 0);
    expect_out("hold5_again", 8'h20, 5, 1, 0);
    step(1, 8'h00, 0);
    expect_out("drop5_gap", 8'h00, 5, 0, 0);
    step(1, 8'h00, 0);
    expect_out("idle_after_drop5", 8'h00, 5, 0, 0);

    // Mid-grant reset with owner 6, then ptr=0 sends req=C0 to index 6
    step(1, 8'h40, 0);
    expect_out("grant6", 8'h40, 6, 1, 0);
    step(0, 8'h40, 0);
    expect_out("midgrant_reset", 8'h00, 0, 0, 0);
    step(1, 8'hC0, 0);
    expect_out("post_reset_grant", 8'h40, 6, 1, 0);
    step(1, 8'hC0, 1);
    expect_out("post_reset_gap", 8'h00, 6, 0, 0);
    step(1, 8'hC0, 0);
    expect_out("post_reset_next", 8'h80, 7, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
